// File: rtl/gib_fetch_responder.sv
// gib_fetch_responder
// Responder end of the instruction-fetch request/return protocol. Accepts one
// request at a time, reads up to BEAT_WORDS words from the instruction RAM and
// returns them as a single response beat.
// Optional build macro: GIB_FETCH_RESPONDER_PARITY_EN adds the mem_rpar input
// and checks even parity on every captured word. A parity error zeroes rsp_len
// and pulses err in the response cycle.
module gib_fetch_responder #(
    parameter int ADDR_W      = 32,
    parameter int GIB_WIDTH   = 32,
    parameter int GIB_MULTI   = 4,
    parameter int BEAT_WORDS  = 8,
    parameter int LEN_W       = 8,
    parameter int MEM_LATENCY = 2
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            req_valid,
    output logic                            req_ready,
    input  logic [ADDR_W-1:0]               req_addr,
    input  logic [LEN_W-1:0]                req_len,
    input  logic                            req_is_gib,
    output logic                            busy,
    output logic                            mem_ren,
    output logic [ADDR_W-3:0]               mem_raddr,
    input  logic [GIB_WIDTH-1:0]            mem_rdata,
`ifdef GIB_FETCH_RESPONDER_PARITY_EN
    input  logic                            mem_rpar,
`endif
    output logic                            rsp_valid,
    output logic [LEN_W-1:0]                rsp_len,
    output logic                            rsp_is_gib,
    output logic [BEAT_WORDS*GIB_WIDTH-1:0] rsp_data,
    output logic                            err
);

    localparam int WADDR_W = ADDR_W - 2;
    localparam int SLOT_W  = (BEAT_WORDS > 1) ? $clog2(BEAT_WORDS) : 1;
    localparam int CNT_W   = $clog2(BEAT_WORDS + 1);

    typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RESP} fetchState;

    fetchState stateReg, stateNext;

    // Latched request
    logic [WADDR_W-1:0] baseReg;
    logic [LEN_W-1:0]   lenReg;
    logic               gibReg;
    logic [CNT_W-1:0]   numReg;
    logic [SLOT_W-1:0]  issueIdxReg;

    // Capture buffer and read-tag pipeline
    logic [GIB_WIDTH-1:0] slotReg    [BEAT_WORDS];
    logic                 tagValidReg[MEM_LATENCY];
    logic [SLOT_W-1:0]    tagSlotReg [MEM_LATENCY];

    // Response registers
    logic [BEAT_WORDS*GIB_WIDTH-1:0] rspDataReg, rspDataNext;
    logic [LEN_W-1:0]                rspLenReg;
    logic                            rspGibReg;
    logic                            errReg;
    logic                            parBadReg;

    logic              accept, reqOk, capture, issueLast, respEnter;
    logic              captureBad, respBad;
    logic [LEN_W-1:0]  reqWords;
    logic [SLOT_W-1:0] captureSlot, lastSlot;

    assign reqWords = req_len / LEN_W'(GIB_MULTI);
    assign reqOk    = (req_len != '0)
                   && ((req_len % LEN_W'(GIB_MULTI)) == '0)
                   && (reqWords <= LEN_W'(BEAT_WORDS))
                   && ((req_addr % ADDR_W'(GIB_MULTI)) == '0);
    assign accept   = (stateReg == IDLE) && req_valid;

    // The oldest tag stage lines up with the cycle its RAM data is valid
    assign capture     = tagValidReg[MEM_LATENCY-1];
    assign captureSlot = tagSlotReg[MEM_LATENCY-1];
    assign lastSlot    = SLOT_W'(numReg - CNT_W'(1));
    assign issueLast   = (issueIdxReg == lastSlot);
    assign respEnter   = (stateReg == DRAIN) && capture && (captureSlot == lastSlot);

`ifdef GIB_FETCH_RESPONDER_PARITY_EN
    assign captureBad = capture && ((^mem_rdata) != mem_rpar);
`else
    assign captureBad = 1'b0;
`endif
    // Include the word being captured this cycle, since the last capture and
    // the response load happen on the same edge
    assign respBad = parBadReg | captureBad;

    // Response beat: buffer contents merged with the word arriving now, unused
    // slots forced to zero
    generate
        for (genvar gi = 0; gi < BEAT_WORDS; gi++) begin : gSlot
            assign rspDataNext[gi*GIB_WIDTH +: GIB_WIDTH] =
                (CNT_W'(gi) >= numReg)                        ? '0        :
                (capture && (captureSlot == SLOT_W'(gi)))     ? mem_rdata :
                                                                slotReg[gi];
        end
    endgenerate

    // FSM state register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stateReg <= IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // Next-state logic and handshake / RAM outputs decoded from the state
    always_comb begin
        stateNext = stateReg;
        req_ready = 1'b0;
        busy      = 1'b0;
        mem_ren   = 1'b0;
        mem_raddr = '0;
        rsp_valid = 1'b0;
        case (stateReg)
            IDLE: begin
                req_ready = !reset;
                if (req_valid && reqOk) begin
                    stateNext = ISSUE;
                end
            end
            ISSUE: begin
                busy      = 1'b1;
                mem_ren   = 1'b1;
                mem_raddr = baseReg + WADDR_W'(issueIdxReg);
                if (issueLast) begin
                    stateNext = DRAIN;
                end
            end
            DRAIN: begin
                busy = 1'b1;
                if (respEnter) begin
                    stateNext = RESP;
                end
            end
            RESP: begin
                busy      = 1'b1;
                rsp_valid = 1'b1;
                stateNext = IDLE;
            end
            default: stateNext = IDLE;
        endcase
    end

    // Slot-index tag pipeline matching the RAM read latency
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < MEM_LATENCY; i++) begin
                tagValidReg[i] <= 1'b0;
                tagSlotReg[i]  <= '0;
            end
        end else begin
            tagValidReg[0] <= (stateReg == ISSUE);
            tagSlotReg[0]  <= issueIdxReg;
            for (int i = 1; i < MEM_LATENCY; i++) begin
                tagValidReg[i] <= tagValidReg[i-1];
                tagSlotReg[i]  <= tagSlotReg[i-1];
            end
        end
    end

    // Request latch, issue counter, capture buffer and response registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            baseReg     <= '0;
            lenReg      <= '0;
            gibReg      <= 1'b0;
            numReg      <= '0;
            issueIdxReg <= '0;
            for (int i = 0; i < BEAT_WORDS; i++) begin
                slotReg[i] <= '0;
            end
            rspDataReg  <= '0;
            rspLenReg   <= '0;
            rspGibReg   <= 1'b0;
            errReg      <= 1'b0;
            parBadReg   <= 1'b0;
        end else begin
            errReg <= 1'b0;
            if (accept) begin
                baseReg     <= req_addr[ADDR_W-1:2];
                lenReg      <= req_len;
                gibReg      <= req_is_gib;
                numReg      <= CNT_W'(reqWords);
                issueIdxReg <= '0;
                parBadReg   <= 1'b0;
                for (int i = 0; i < BEAT_WORDS; i++) begin
                    slotReg[i] <= '0;
                end
                if (!reqOk) begin
                    errReg <= 1'b1;
                end
            end
            if (stateReg == ISSUE) begin
                issueIdxReg <= issueIdxReg + SLOT_W'(1);
            end
            if (capture) begin
                slotReg[captureSlot] <= mem_rdata;
                if (captureBad) begin
                    parBadReg <= 1'b1;
                end
            end
            if (respEnter) begin
                rspDataReg <= rspDataNext;
                rspLenReg  <= respBad ? '0 : lenReg;
                rspGibReg  <= gibReg;
                errReg     <= respBad;
            end
        end
    end

    assign rsp_data   = rspDataReg;
    assign rsp_len    = rspLenReg;
    assign rsp_is_gib = rspGibReg;
    assign err        = errReg;

endmodule
